// File: rtl/fp32_argmax_stream.sv
// ---------------------------------------------------------------------------
// fp32_argmax_stream
//
// Streaming reduction over packets of ordered FP32 keys. Each packet is a run
// of beats terminated by in_last. The block returns the extreme key of the
// packet and the 0-based index of its first occurrence. Keys are compared as
// unsigned integers; the upstream translator has already made their order
// match the float order.
//
// Build option:
//   FP32_ARGMIN_EN  defined   -> strictly-less compare (argmin)
//                   undefined -> strictly-greater compare (argmax, default)
//
// Parameters:
//   IDX_W         width of index and count (saturate at 2^IDX_W-1)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_valid      input beat valid
//   in_ready      block can accept a beat (low while a result is held)
//   in_key        ordered key
//   in_is_nan     beat is NaN; key ignored, still counted and indexed
//   in_is_zero    beat is +0/-0; key replaced by canonical zero 0x80000000
//   in_last       final beat of packet
//   out_valid     result valid (held until out_ready)
//   out_ready     consumer accepts the result
//   out_key       winning key (0 when every beat was NaN)
//   out_idx       index of winner (all-ones when every beat was NaN)
//   out_count     beats accepted in packet (saturating)
//   out_nan_seen  at least one NaN beat in packet
//   out_ovf       packet was longer than 2^IDX_W-1 beats
// ---------------------------------------------------------------------------
module fp32_argmax_stream #(
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_key,
    input  logic             in_is_nan,
    input  logic             in_is_zero,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_key,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_nan_seen,
    output logic             out_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [IDX_W-1:0] IDX_MAX  = '1;
    localparam logic [31:0]      ZERO_KEY = 32'h8000_0000;

    logic [1:0]       state_reg;
    logic [31:0]      best_key_reg;
    logic [IDX_W-1:0] best_idx_reg;
    logic             have_best_reg;
    logic [IDX_W-1:0] count_reg;
    logic             nan_seen_reg;
    logic             ovf_reg;

    logic             accept;
    logic [31:0]      canon_key;
    logic             wins;
    logic             take_next;
    logic [IDX_W-1:0] count_next;
    logic             count_sat;

    // in_ready is gated by rst_n so that nothing is accepted while reset
    // is being applied, even though the state register itself is IDLE.
    assign in_ready  = rst_n && (state_reg != ST_HOLD);
    assign out_valid = (state_reg == ST_HOLD);
    assign accept    = in_valid && in_ready;

    // -0 and +0 must tie, so both collapse to the same key.
    assign canon_key = in_is_zero ? ZERO_KEY : in_key;

`ifdef FP32_ARGMIN_EN
    assign wins = canon_key < best_key_reg;
`else
    assign wins = canon_key > best_key_reg;
`endif

    // Strict compare keeps the earliest index on ties; NaN never competes.
    assign take_next  = !in_is_nan && (!have_best_reg || wins);

    // count_reg doubles as the index of the incoming beat; once it has
    // saturated, further beats share index IDX_MAX.
    assign count_sat  = (count_reg == IDX_MAX);
    assign count_next = count_sat ? IDX_MAX : count_reg + 1'b1;

    assign out_key      = best_key_reg;
    assign out_idx      = best_idx_reg;
    assign out_count    = count_reg;
    assign out_nan_seen = nan_seen_reg;
    assign out_ovf      = ovf_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            best_key_reg  <= '0;
            best_idx_reg  <= '0;
            have_best_reg <= 1'b0;
            count_reg     <= '0;
            nan_seen_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        count_reg    <= count_next;
                        ovf_reg      <= ovf_reg || count_sat;
                        nan_seen_reg <= nan_seen_reg || in_is_nan;
                        if (take_next) begin
                            best_key_reg  <= canon_key;
                            best_idx_reg  <= count_reg;
                            have_best_reg <= 1'b1;
                        end
                        if (in_last) begin
                            state_reg <= ST_HOLD;
                            // No non-NaN beat in the whole packet: flag the
                            // index as invalid; best_key_reg is still zero.
                            if (!take_next && !have_best_reg) begin
                                best_idx_reg <= IDX_MAX;
                            end
                        end else begin
                            state_reg <= ST_ACC;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        best_key_reg  <= '0;
                        best_idx_reg  <= '0;
                        have_best_reg <= 1'b0;
                        count_reg     <= '0;
                        nan_seen_reg  <= 1'b0;
                        ovf_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_argmax_stream.sv
// ---------------------------------------------------------------------------
// tb_fp32_argmax_stream
//
// Drives two instances (IDX_W=16 and IDX_W=4) with the same beat stream.
// A packet-level reference model collects accepted beats, computes the
// expected result when the last beat arrives, and a single compare process
// checks ready/valid and the held result of both instances every cycle.
// Directed packets additionally check hand-computed literals.
// ---------------------------------------------------------------------------
module tb_fp32_argmax_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_key;
    logic        in_is_nan;
    logic        in_is_zero;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_nan_seen, a_out_ovf;
    logic [31:0] a_out_key;
    logic [15:0] a_out_idx, a_out_count;
    logic        b_in_ready, b_out_valid, b_out_nan_seen, b_out_ovf;
    logic [31:0] b_out_key;
    logic [3:0]  b_out_idx, b_out_count;

    always #5 clk = ~clk;

    fp32_argmax_stream #(.IDX_W(16)) u_w16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_key(in_key),
        .in_is_nan(in_is_nan), .in_is_zero(in_is_zero), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_key(a_out_key),
        .out_idx(a_out_idx), .out_count(a_out_count),
        .out_nan_seen(a_out_nan_seen), .out_ovf(a_out_ovf)
    );

    fp32_argmax_stream #(.IDX_W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_key(in_key),
        .in_is_nan(in_is_nan), .in_is_zero(in_is_zero), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_key(b_out_key),
        .out_idx(b_out_idx), .out_count(b_out_count),
        .out_nan_seen(b_out_nan_seen), .out_ovf(b_out_ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] key;
        logic [31:0] idx;
        logic [31:0] count;
        logic        nan;
        logic        ovf;
    } res_t;

    logic [31:0] q_key[$];
    bit          q_nan[$];
    bit          q_zero[$];
    bit          have_res = 1'b0;
    res_t        r16, r4;

    function automatic bit better(input logic [31:0] k, input logic [31:0] best);
`ifdef FP32_ARGMIN_EN
        return k < best;
`else
        return k > best;
`endif
    endfunction

    function automatic res_t compute(input int w);
        res_t        r;
        longint      maxv = (longint'(1) << w) - 1;
        longint      n    = q_key.size();
        bit          found = 1'b0;
        logic [31:0] k;
        r.key = 32'h0;
        r.idx = 32'(maxv);
        r.nan = 1'b0;
        for (int i = 0; i < q_key.size(); i++) begin
            if (q_nan[i]) begin
                r.nan = 1'b1;
            end else begin
                k = q_zero[i] ? 32'h8000_0000 : q_key[i];
                if (!found || better(k, r.key)) begin
                    r.key = k;
                    r.idx = (i < maxv) ? 32'(i) : 32'(maxv);
                    found = 1'b1;
                end
            end
        end
        r.count = (n < maxv) ? 32'(n) : 32'(maxv);
        r.ovf   = (n > maxv);
        return r;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        logic exp_rdy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_rdy = rst_n && !have_res;
            chk("in_ready_w16", a_in_ready, exp_rdy);
            chk("in_ready_w4", b_in_ready, exp_rdy);
            chk("out_valid_w16", a_out_valid, have_res);
            chk("out_valid_w4", b_out_valid, have_res);
            if (have_res) begin
                chk("out_key_w16", a_out_key, r16.key);
                chk("out_idx_w16", a_out_idx, r16.idx);
                chk("out_count_w16", a_out_count, r16.count);
                chk("out_nan_w16", a_out_nan_seen, r16.nan);
                chk("out_ovf_w16", a_out_ovf, r16.ovf);
                chk("out_key_w4", b_out_key, r4.key);
                chk("out_idx_w4", b_out_idx, r4.idx);
                chk("out_count_w4", b_out_count, r4.count);
                chk("out_nan_w4", b_out_nan_seen, r4.nan);
                chk("out_ovf_w4", b_out_ovf, r4.ovf);
            end
            if (!rst_n) begin
                q_key.delete(); q_nan.delete(); q_zero.delete();
                have_res = 1'b0;
            end else if (have_res) begin
                if (out_ready) have_res = 1'b0;
            end else if (in_valid) begin
                q_key.push_back(in_key);
                q_nan.push_back(in_is_nan);
                q_zero.push_back(in_is_zero);
                if (in_last) begin
                    r16 = compute(16);
                    r4  = compute(4);
                    have_res = 1'b1;
                    q_key.delete(); q_nan.delete(); q_zero.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] k, input bit nan, input bit zero,
                        input bit last, input bit rnd);
        bit ok = 1'b0;
        in_key = k; in_is_nan = nan; in_is_zero = zero; in_last = last;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (a_in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout actual=no_accept required=accept (t=%0t)", $time);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result();
        bit ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (a_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL result_timeout actual=no_valid required=valid (t=%0t)", $time);
        end
    endtask

    task automatic release_result();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] key, input logic [31:0] idx,
                       input logic [31:0] cnt, input logic nan);
        chk({nm, "_key"}, a_out_key, key);
        chk({nm, "_idx"}, a_out_idx, idx);
        chk({nm, "_count"}, a_out_count, cnt);
        chk({nm, "_nan"}, a_out_nan_seen, nan);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pool [4];
        logic [31:0] k;
        int          len;

        rst_n = 1'b0; in_valid = 1'b0; in_key = '0; in_is_nan = 1'b0;
        in_is_zero = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_key", a_out_key, 32'h0);
        chk("rst_out_idx", a_out_idx, 16'h0);
        chk("rst_out_count", b_out_count, 4'h0);
        chk("rst_flags", {a_out_nan_seen, a_out_ovf}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 1 + hold: ordered keys for 1.0, 2.0, -1.0
        send(32'hBF80_0000, 0, 0, 0, 0);
        send(32'hC000_0000, 0, 0, 0, 0);
        send(32'h407F_FFFF, 0, 0, 1, 0);
        wait_result();
`ifdef FP32_ARGMIN_EN
        lit("t1", 32'h407F_FFFF, 2, 3, 0);
`else
        lit("t1", 32'hC000_0000, 1, 3, 0);
`endif
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_hold_in_ready", a_in_ready, 1'b0);
        chk("t4_hold_valid", a_out_valid, 1'b1);
        release_result();

        // Test 2: -0 then +0 tie
        send(32'h7FFF_FFFF, 0, 1, 0, 0);
        send(32'h8000_0000, 0, 1, 1, 0);
        wait_result();
        lit("t2", 32'h8000_0000, 0, 2, 0);
        release_result();

        // Test 3: NaN skipping and all-NaN packet
        send(32'h1234_5678, 1, 0, 0, 0);
        send(32'hBF80_0000, 0, 0, 0, 0);
        send(32'hFFFF_FFFF, 1, 0, 1, 0);
        wait_result();
        lit("t3", 32'hBF80_0000, 1, 3, 1);
        release_result();
        send(32'hFFC0_0000, 1, 0, 0, 0);
        send(32'h0000_0001, 1, 0, 1, 0);
        wait_result();
        lit("t3_allnan", 32'h0, 16'hFFFF, 2, 1);
        chk("t3_allnan_idx_w4", b_out_idx, 4'hF);
        release_result();

        // Test 4: back-to-back single-beat packets with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h4000_0000 + i, 0, 0, 1, 0);
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;

        // Test 5: reset after 2 beats discards the packet
        send(32'hAAAA_0000, 0, 0, 0, 0);
        send(32'hBBBB_0000, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        send(32'h1111_2222, 0, 0, 1, 0);
        wait_result();
        lit("t5", 32'h1111_2222, 0, 1, 0);
        release_result();

        // Test 6: 20 beats, extreme at beat 18
        for (int i = 0; i < 20; i++) begin
`ifdef FP32_ARGMIN_EN
            k = (i == 18) ? 32'h0000_0010 : 32'h4000_0000 + i;
`else
            k = (i == 18) ? 32'hF000_0000 : 32'h4000_0000 + i;
`endif
            send(k, 0, 0, (i == 19), 0);
        end
        wait_result();
        chk("t6_idx_w4", b_out_idx, 4'hF);
        chk("t6_count_w4", b_out_count, 4'hF);
        chk("t6_ovf_w4", b_out_ovf, 1'b1);
        chk("t6_idx_w16", a_out_idx, 16'd18);
        chk("t6_count_w16", a_out_count, 16'd20);
        chk("t6_ovf_w16", a_out_ovf, 1'b0);
        release_result();

        // Randomized packets: ties, NaNs, zeros, back-pressure, stray resets
        for (int p = 0; p < 60; p++) begin
            for (int j = 0; j < 4; j++) pool[j] = $urandom;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                k = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
                send(k, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                     (i == len - 1), 1);
                if (i == 1 && $urandom_range(0, 24) == 0) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    break;
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end

        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
